// File: rtl/load_store_unit.sv
// Load/store unit: sequences byte/halfword/word accesses to a word-wide memory,
// with read-modify-write for sub-word stores. Optional macro MISALIGN_TRAP_EN traps misaligned accesses.
module load_store_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] m_addr,
    output logic [31:0] m_wd,
    input  logic [31:0] m_rd
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t      state;
    logic        we_q;
    logic        uns_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] word_q;

    logic        illegal;
    logic [31:0] sh_b;
    logic [31:0] sh_h;
    logic [31:0] ld_ext;
    logic [31:0] merged;

    always_comb begin
        illegal = (size == 2'b11);
`ifdef MISALIGN_TRAP_EN
        if (size == 2'b01 && addr[0])
            illegal = 1'b1;
        if (size == 2'b10 && addr[1:0] != 2'b00)
            illegal = 1'b1;
`endif
    end

    // Load extraction works on the live memory word so rdata is ready on the RD->DONE edge.
    always_comb begin
        sh_b = m_rd >> {addr_q[1:0], 3'b000};
        sh_h = m_rd >> {addr_q[1], 4'b0000};
        case (size_q)
            2'b00:   ld_ext = {{24{~uns_q & sh_b[7]}}, sh_b[7:0]};
            2'b01:   ld_ext = {{16{~uns_q & sh_h[15]}}, sh_h[15:0]};
            default: ld_ext = m_rd;
        endcase
    end

    always_comb begin
        merged = word_q;
        case (size_q)
            2'b00:   merged[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
            2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: merged = wdata_q;
        endcase
    end

    assign ready    = (state == IDLE);
    assign done     = (state == DONE);
    assign MemRead  = (state == RD);
    assign MemWrite = (state == WR);
    assign m_addr   = {addr_q[31:2], 2'b00};
    assign m_wd     = merged;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            we_q    <= '0;
            uns_q   <= '0;
            size_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            word_q  <= '0;
            err     <= '0;
            rdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        we_q    <= we;
                        uns_q   <= uns;
                        size_q  <= size;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        if (illegal) begin
                            state <= DONE;
                            err   <= 1'b1;
                        end else if (we && size == 2'b10) begin
                            state <= WR;
                        end else begin
                            state <= RD;
                        end
                    end
                end
                RD: begin
                    word_q <= m_rd;
                    if (we_q) begin
                        state <= WR;
                    end else begin
                        state <= DONE;
                        rdata <= ld_ext;
                        err   <= 1'b0;
                    end
                end
                WR: begin
                    state <= DONE;
                    err   <= 1'b0;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
